// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared op encodings, ALU controls, state type and result
//                selection helper for the iterative multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // op[1:0] encodings; op[OP_SIGNED_BIT] selects signed operation
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;
    localparam int         OP_SIGNED_BIT = 2;

    // ALU control codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    // Step counter width: 32 iterations
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // acc holds hi (multiply) or rem (divide); shr holds lo or quo
    function automatic logic [31:0] pick_result(input logic [1:0]  kind,
                                                input logic [31:0] acc,
                                                input logic [31:0] shr);
        logic [31:0] sel;
        case (kind)
            OP_MUL:  sel = shr;
            OP_MULH: sel = acc;
            OP_DIV:  sel = shr;
            default: sel = acc;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 32-bit add/subtract ALU with carry-out and status flags.
//                Subtract is A + ~B + 1, so carry=1 means "no borrow".
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import muldiv_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        carry,
    output logic        overflow,
    output logic        zero,
    output logic        negative
);

    logic        is_sub;
    logic [31:0] b_eff;
    logic [32:0] full;

    // Single adder shared by add and subtract
    always_comb begin
        is_sub   = (ctrl == ALU_SUB);
        b_eff    = is_sub ? ~b : b;
        full     = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};
        sum      = full[31:0];
        carry    = full[32];
        overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);
        zero     = (sum == 32'd0);
        negative = sum[31];
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative 32-step shift-add multiplier / restoring divider
//                built around a single shared ALU.
//                Optional macro MULDIV_SIGNED_EN enables signed operation
//                (operand magnitudes at start, sign fix-up in a FIX state).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       kind, kind_nxt;
    logic [XLEN-1:0]  acc, acc_nxt;     // hi / rem
    logic [XLEN-1:0]  shr, shr_nxt;     // lo / quo
    logic [XLEN-1:0]  opnd, opnd_nxt;   // mcand / dvsr
    logic [XLEN-1:0]  result_nxt;

    logic [3:0]       alu_ctrl;
    logic [XLEN-1:0]  alu_a, alu_b, alu_sum;
    logic             alu_carry, alu_ovf, alu_zero, alu_neg;

    logic [XLEN-1:0]  rs;               // partial remainder shifted left by one
    logic [XLEN-1:0]  a_mag, b_mag;

    assign rs = {acc[XLEN-2:0], shr[XLEN-1]};

    // Flags are not needed by the sequencer; op[2] is only meaningful with signed support
    wire unused_flags   = &{1'b0, alu_ovf, alu_zero, alu_neg};
    wire unused_op_sign = op[OP_SIGNED_BIT];

`ifdef MULDIV_SIGNED_EN
    logic fix_r, fix_nxt;               // a sign fix-up cycle is scheduled
    logic neg_r, neg_nxt;               // the final result must be negated
    logic signed_op;

    assign signed_op = op[OP_SIGNED_BIT];
    // In the start cycle the ALU is free and computes 0 - a
    assign a_mag = (signed_op && a[XLEN-1]) ? alu_sum : a;
    assign b_mag = (signed_op && b[XLEN-1]) ? (~b + 1'b1) : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    alu u_alu (
        .ctrl     (alu_ctrl),
        .a        (alu_a),
        .b        (alu_b),
        .sum      (alu_sum),
        .carry    (alu_carry),
        .overflow (alu_ovf),
        .zero     (alu_zero),
        .negative (alu_neg)
    );

    // ALU operand and control selection for the current cycle
    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_a    = acc;
        alu_b    = opnd;
        case (state)
            ST_RUN: begin
                if (kind[1]) begin
                    alu_ctrl = ALU_SUB;
                    alu_a    = rs;
                end
            end
`ifdef MULDIV_SIGNED_EN
            ST_IDLE, ST_DONE: begin
                alu_ctrl = ALU_SUB;
                alu_a    = '0;
                alu_b    = a;
            end
            ST_FIX: begin
                if (kind == OP_MULH) begin
                    // high word of the 64-bit negate: ~hi + (lo == 0)
                    alu_ctrl = ALU_ADD;
                    alu_a    = ~acc;
                    alu_b    = {{(XLEN-1){1'b0}}, (shr == '0)};
                end else if (kind == OP_REM) begin
                    alu_ctrl = ALU_SUB;
                    alu_a    = '0;
                    alu_b    = acc;
                end else begin
                    alu_ctrl = ALU_SUB;
                    alu_a    = '0;
                    alu_b    = shr;
                end
            end
`endif
            default: ;
        endcase
    end

    // Next-state, datapath step and result capture
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        kind_nxt   = kind;
        acc_nxt    = acc;
        shr_nxt    = shr;
        opnd_nxt   = opnd;
        result_nxt = result;
`ifdef MULDIV_SIGNED_EN
        fix_nxt    = fix_r;
        neg_nxt    = neg_r;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    kind_nxt = op[1:0];
                    cnt_nxt  = '0;
`ifdef MULDIV_SIGNED_EN
                    fix_nxt  = signed_op && (a[XLEN-1] || b[XLEN-1]);
                    neg_nxt  = (op[1:0] == OP_REM) ? a[XLEN-1] : (a[XLEN-1] ^ b[XLEN-1]);
`endif
                    if (op[1]) begin
                        if (b == '0) begin
                            // divide by zero: skip the iterations entirely
                            acc_nxt    = a;
                            shr_nxt    = '1;
                            opnd_nxt   = b;
                            result_nxt = pick_result(op[1:0], a, '1);
                            state_nxt  = ST_DONE;
`ifdef MULDIV_SIGNED_EN
                            fix_nxt    = 1'b0;
`endif
                        end else begin
                            acc_nxt   = '0;
                            shr_nxt   = a_mag;
                            opnd_nxt  = b_mag;
                            state_nxt = ST_RUN;
                        end
                    end else begin
                        acc_nxt   = '0;
                        shr_nxt   = b_mag;
                        opnd_nxt  = a_mag;
                        state_nxt = ST_RUN;
                    end
                end else if (state == ST_DONE) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!kind[1]) begin
                    if (shr[0]) begin
                        {acc_nxt, shr_nxt} = {alu_carry, alu_sum, shr[XLEN-1:1]};
                    end else begin
                        {acc_nxt, shr_nxt} = {1'b0, acc, shr[XLEN-1:1]};
                    end
                end else begin
                    if (acc[XLEN-1] || alu_carry) begin
                        acc_nxt = alu_sum;
                        shr_nxt = {shr[XLEN-2:0], 1'b1};
                    end else begin
                        acc_nxt = rs;
                        shr_nxt = {shr[XLEN-2:0], 1'b0};
                    end
                end
                cnt_nxt = cnt + 1'b1;
                if (cnt == {CNT_W{1'b1}}) begin
`ifdef MULDIV_SIGNED_EN
                    if (fix_r) begin
                        state_nxt = ST_FIX;
                    end else begin
                        state_nxt  = ST_DONE;
                        result_nxt = pick_result(kind, acc_nxt, shr_nxt);
                    end
`else
                    state_nxt  = ST_DONE;
                    result_nxt = pick_result(kind, acc_nxt, shr_nxt);
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            ST_FIX: begin
                result_nxt = neg_r ? alu_sum : pick_result(kind, acc, shr);
                state_nxt  = ST_DONE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            kind   <= 2'b00;
            acc    <= '0;
            shr    <= '0;
            opnd   <= '0;
            result <= '0;
`ifdef MULDIV_SIGNED_EN
            fix_r  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            kind   <= kind_nxt;
            acc    <= acc_nxt;
            shr    <= shr_nxt;
            opnd   <= opnd_nxt;
            result <= result_nxt;
`ifdef MULDIV_SIGNED_EN
            fix_r  <= fix_nxt;
            neg_r  <= neg_nxt;
`endif
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_FIX);
    assign done = (state == ST_DONE);

endmodule
`default_nettype wire
